// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO sitting between the EX/MEM pipeline
// register and the data memory controller. Stores retire in one cycle and
// drain in the background; loads take the memory port directly unless they
// hit a buffered word, in which case they stall until that word has drained.
// Optional macro STORE_FWD_EN: an aligned word load that hits a word store
// with the identical address takes the youngest entry's data without stalling.
//
// Handshake: the pipeline presents mem_read/mem_write with stable inputs and
// treats a cycle as consumed only when stall=0. Toward memory, dm_read or
// dm_write (never both) offers an op that completes on a rising edge with
// dm_stall=0; otherwise the same op stays offered.
module store_buffer #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [1:0]            load_store_type,
   input  logic                  load_unsigned,
   input  logic                  drain_req,
   output logic                  stall,
   output logic [DATA_WIDTH-1:0] mem_read_data,
   output logic [ADDR_WIDTH-1:0] dm_addr,
   output logic [DATA_WIDTH-1:0] dm_write_data,
   output logic [1:0]            dm_load_store_type,
   output logic                  dm_load_unsigned,
   output logic                  dm_read,
   output logic                  dm_write,
   input  logic [DATA_WIDTH-1:0] dm_read_data,
   input  logic                  dm_stall
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
`ifdef STORE_FWD_EN
   localparam logic [1:0] LS_WORD = 2'b10;
`endif

   // Entry payload {addr, data, type}; load_unsigned is never stored because
   // drained stores always present dm_load_unsigned=0.
   logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
   logic [DATA_WIDTH-1:0] r_data [DEPTH];
   logic [1:0]            r_type [DEPTH];
   logic [DEPTH-1:0]      r_valid;
   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [CW-1:0]         r_count;

   logic                  w_load_req;
   logic                  w_hit;
   logic [PW-1:0]         w_idx;
   logic [PW-1:0]         w_young_idx;
   logic                  w_fwd;
   logic                  w_load_port;
   logic                  w_hit_stall;
   logic                  w_drain;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_full;
   logic                  w_nonempty;

   // A simultaneous store wins; the read half of an illegal read+write is dropped.
   assign w_load_req = mem_read & ~mem_write & ~rst;
   assign w_full     = (r_count == FULL_COUNT);
   assign w_nonempty = (r_count != '0);

   // Word-granular hit scan from oldest to youngest so the last match seen
   // is the youngest matching entry.
   always_comb begin
      w_hit       = 1'b0;
      w_idx       = '0;
      w_young_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_head + PW'(k);
         if (r_valid[w_idx] &&
             (r_addr[w_idx][ADDR_WIDTH-1:2] == mem_addr[ADDR_WIDTH-1:2])) begin
            w_hit       = 1'b1;
            w_young_idx = w_idx;
         end
      end
   end

`ifdef STORE_FWD_EN
   assign w_fwd = w_load_req & w_hit &
                  (r_type[w_young_idx] == LS_WORD) &
                  (load_store_type == LS_WORD) &
                  (r_addr[w_young_idx] == mem_addr);
`else
   assign w_fwd = 1'b0;
`endif

   // A non-hitting load owns the port; otherwise the head entry drains.
   assign w_load_port = w_load_req & ~w_hit;
   assign w_hit_stall = w_load_req & w_hit & ~w_fwd;
   assign w_drain     = ~rst & ~w_load_port & w_nonempty;
   assign w_pop       = w_drain & ~dm_stall;

   // Full is judged on the registered count: a pop in the same cycle does
   // not make room until the next cycle.
   assign stall = ~rst & ((mem_write & w_full) |
                          w_hit_stall |
                          (w_load_port & dm_stall) |
                          (drain_req & w_nonempty));

   assign w_push = mem_write & ~stall & ~rst;

   // Memory port mux and load data return.
   always_comb begin
      dm_read            = w_load_port;
      dm_write           = w_drain;
      dm_addr            = '0;
      dm_write_data      = '0;
      dm_load_store_type = '0;
      dm_load_unsigned   = 1'b0;
      mem_read_data      = '0;
      if (w_load_port) begin
         dm_addr            = mem_addr;
         dm_load_store_type = load_store_type;
         dm_load_unsigned   = load_unsigned;
         mem_read_data      = dm_read_data;
      end else if (w_drain) begin
         dm_addr            = r_addr[r_head];
         dm_write_data      = r_data[r_head];
         dm_load_store_type = r_type[r_head];
      end
`ifdef STORE_FWD_EN
      if (w_fwd) begin
         mem_read_data = r_data[w_young_idx];
      end
`endif
   end

   // Queue control: pointers, valid bits and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         if (w_push) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + PW'(1);
         end
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload capture at the tail; slot contents are qualified by r_valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail] <= mem_addr;
         r_data[r_tail] <= mem_write_data;
         r_type[r_tail] <= load_store_type;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a byte-array memory model answers the
// dm port, and every accepted store is queued as an expected dm_write.
module tb_store_buffer;

   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [1:0]  load_store_type;
   logic        load_unsigned;
   logic        drain_req;
   logic        stall;
   logic [31:0] mem_read_data;
   logic [31:0] dm_addr;
   logic [31:0] dm_write_data;
   logic [1:0]  dm_load_store_type;
   logic        dm_load_unsigned;
   logic        dm_read;
   logic        dm_write;
   logic [31:0] dm_read_data;
   logic        dm_stall;

   int n_tests = 0;
   int n_fail  = 0;

   logic [65:0] exp_q[$];
   logic [7:0]  mem [256] = '{default: 8'h00};
   logic [7:0]  w_ra;

   store_buffer dut (
      .clk                (clk),
      .rst                (rst),
      .mem_read           (mem_read),
      .mem_write          (mem_write),
      .mem_addr           (mem_addr),
      .mem_write_data     (mem_write_data),
      .load_store_type    (load_store_type),
      .load_unsigned      (load_unsigned),
      .drain_req          (drain_req),
      .stall              (stall),
      .mem_read_data      (mem_read_data),
      .dm_addr            (dm_addr),
      .dm_write_data      (dm_write_data),
      .dm_load_store_type (dm_load_store_type),
      .dm_load_unsigned   (dm_load_unsigned),
      .dm_read            (dm_read),
      .dm_write           (dm_write),
      .dm_read_data       (dm_read_data),
      .dm_stall           (dm_stall)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: little-endian bytes, extension done on read.
   always_comb begin
      w_ra         = dm_addr[7:0];
      dm_read_data = 32'h0;
      case (dm_load_store_type)
         LS_BYTE: dm_read_data = dm_load_unsigned ? {24'h0, mem[w_ra]}
                                                  : {{24{mem[w_ra][7]}}, mem[w_ra]};
         LS_HALF: dm_read_data = dm_load_unsigned ? {16'h0, mem[w_ra + 8'd1], mem[w_ra]}
                                                  : {{16{mem[w_ra + 8'd1][7]}}, mem[w_ra + 8'd1], mem[w_ra]};
         default: dm_read_data = {mem[w_ra + 8'd3], mem[w_ra + 8'd2], mem[w_ra + 8'd1], mem[w_ra]};
      endcase
   end

   always @(posedge clk) begin
      if (!rst && dm_write && !dm_stall) begin
         case (dm_load_store_type)
            LS_BYTE: mem[dm_addr[7:0]] <= dm_write_data[7:0];
            LS_HALF: begin
               mem[dm_addr[7:0]]        <= dm_write_data[7:0];
               mem[dm_addr[7:0] + 8'd1] <= dm_write_data[15:8];
            end
            default: begin
               mem[dm_addr[7:0]]        <= dm_write_data[7:0];
               mem[dm_addr[7:0] + 8'd1] <= dm_write_data[15:8];
               mem[dm_addr[7:0] + 8'd2] <= dm_write_data[23:16];
               mem[dm_addr[7:0] + 8'd3] <= dm_write_data[31:24];
            end
         endcase
      end
   end

   function automatic logic [31:0] mem_word(input int a);
      return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
   endfunction

   task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every write taken by memory must be the oldest expected store.
   always @(negedge clk) begin
      if (!rst) begin
         chk("dm_rd_wr_exclusive", 66'(dm_read & dm_write), 66'd0);
         if (dm_write && !dm_stall) begin
            chk("sb_write_expected", 66'(exp_q.size() != 0), 66'd1);
            chk("sb_write_unsigned", 66'(dm_load_unsigned), 66'd0);
            if (exp_q.size() != 0) begin
               chk("sb_write_order", {dm_addr, dm_write_data, dm_load_store_type},
                   exp_q.pop_front());
            end
         end
      end
   end

   // Driver tasks: each starts and ends 1 time unit after a rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] t, output int stalls);
      bit taken;
      taken           = 1'b0;
      stalls          = 0;
      mem_read        = 1'b0;
      mem_write       = 1'b1;
      mem_addr        = a;
      mem_write_data  = d;
      load_store_type = t;
      for (int k = 0; k < 20 && !taken; k++) begin
         @(negedge clk);
         if (!stall) begin
            taken = 1'b1;
            exp_q.push_back({a, d, t});
         end else begin
            stalls++;
         end
         next_cycle();
      end
      mem_write = 1'b0;
      chk("store_accepted", 66'(taken), 66'd1);
   endtask

   task automatic wait_empty(input string tag);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         done = !dm_write;
         next_cycle();
      end
      chk(tag, 66'(done), 66'd1);
   endtask

   int st;

   initial begin
      // Reset with a load request present: all outputs must stay quiet.
      rst             = 1'b1;
      mem_read        = 1'b1;
      mem_write       = 1'b0;
      mem_addr        = 32'd64;
      mem_write_data  = 32'h0;
      load_store_type = LS_WORD;
      load_unsigned   = 1'b0;
      drain_req       = 1'b0;
      dm_stall        = 1'b0;
      #12;
      chk("rst_stall", 66'(stall), 66'd0);
      chk("rst_dm_read", 66'(dm_read), 66'd0);
      chk("rst_dm_write", 66'(dm_write), 66'd0);
      chk("rst_read_data", 66'(mem_read_data), 66'd0);
      mem_read = 1'b0;
      next_cycle();
      rst = 1'b0;

      // Back-to-back word stores retire without stalling and drain in order.
      for (int i = 0; i < 4; i++) begin
         store(32'(i * 4), 32'(i + 1), LS_WORD, st);
         chk("t1_no_stall", 66'(st), 66'd0);
      end
      wait_empty("t1_drained");
      for (int i = 0; i < 4; i++) begin
         chk("t1_mem", 66'(mem_word(i * 4)), 66'(i + 1));
      end

      // Full buffer: fifth store stalls until a pop has happened.
      dm_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         store(32'(32 + i * 4), 32'h10 + 32'(i), LS_WORD, st);
         chk("t2_fill_no_stall", 66'(st), 66'd0);
      end
      mem_write       = 1'b1;
      mem_addr        = 32'd48;
      mem_write_data  = 32'h14;
      load_store_type = LS_WORD;
      @(negedge clk);
      chk("t2_full_stall", 66'(stall), 66'd1);
      next_cycle();
      dm_stall = 1'b0;
      @(negedge clk);
      chk("t2_pop_cycle_stall", 66'(stall), 66'd1);
      chk("t2_pop_cycle_write", 66'(dm_write), 66'd1);
      next_cycle();
      @(negedge clk);
      chk("t2_accept_after_pop", 66'(stall), 66'd0);
      if (!stall) exp_q.push_back({32'd48, 32'h14, LS_WORD});
      next_cycle();
      mem_write = 1'b0;
      wait_empty("t2_drained");
      chk("t2_mem_last", 66'(mem_word(48)), 66'h14);

      // Load hitting a buffered byte stalls until that byte drains.
      dm_stall = 1'b1;
      store(32'd22, 32'h0000_00F0, LS_BYTE, st);
      mem_read        = 1'b1;
      mem_addr        = 32'd20;
      load_store_type = LS_BYTE;
      load_unsigned   = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t3_hit_stall", 66'(stall), 66'd1);
         chk("t3_hit_no_read", 66'(dm_read), 66'd0);
         next_cycle();
      end
      dm_stall = 1'b0;
      @(negedge clk);
      chk("t3_drain_stall", 66'(stall), 66'd1);
      chk("t3_drain_write", 66'(dm_write), 66'd1);
      next_cycle();
      @(negedge clk);
      chk("t3_reissue_stall", 66'(stall), 66'd0);
      chk("t3_reissue_read", 66'(dm_read), 66'd1);
      chk("t3_data_addr20", 66'(mem_read_data), 66'h0);
      next_cycle();
      mem_addr = 32'd22;
      @(negedge clk);
      chk("t3_data_addr22", 66'(mem_read_data), 66'hFFFF_FFF0);
      next_cycle();
      mem_read = 1'b0;

      // Non-hitting load takes the port ahead of a queued store.
      store(32'd150, 32'h0000_009C, LS_BYTE, st);
      wait_empty("t4_pre_drained");
      store(32'd80, 32'h1122_3344, LS_WORD, st);
      mem_read        = 1'b1;
      mem_addr        = 32'd150;
      load_store_type = LS_BYTE;
      load_unsigned   = 1'b1;
      @(negedge clk);
      chk("t4_bypass_read", 66'(dm_read), 66'd1);
      chk("t4_bypass_no_write", 66'(dm_write), 66'd0);
      chk("t4_bypass_stall", 66'(stall), 66'd0);
      chk("t4_bypass_addr", 66'(dm_addr), 66'd150);
      chk("t4_bypass_data", 66'(mem_read_data), 66'h9C);
      next_cycle();
      mem_read = 1'b0;
      @(negedge clk);
      chk("t4_late_write", 66'(dm_write), 66'd1);
      chk("t4_late_addr", 66'(dm_addr), 66'd80);
      next_cycle();
      wait_empty("t4_drained");

      // Fence: stall exactly while entries remain.
      dm_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         store(32'(96 + i * 4), 32'hA0 + 32'(i), LS_WORD, st);
      end
      dm_stall  = 1'b0;
      drain_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t5_fence_stall", 66'(stall), 66'(i < 3));
         chk("t5_fence_write", 66'(dm_write), 66'(i < 3));
         next_cycle();
      end
      drain_req = 1'b0;
      chk("t5_mem_last", 66'(mem_word(104)), 66'hA2);

      // Reset with two stores pending discards them.
      dm_stall = 1'b1;
      store(32'd200, 32'hDEAD_0001, LS_WORD, st);
      store(32'd204, 32'hDEAD_0002, LS_WORD, st);
      #1;
      chk("t5_pre_rst_write", 66'(dm_write), 66'd1);
      rst = 1'b1;
      #1;
      chk("t5_rst_write_drop", 66'(dm_write), 66'd0);
      chk("t5_rst_stall", 66'(stall), 66'd0);
      exp_q.delete();
      dm_stall = 1'b0;
      next_cycle();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t5_post_rst_idle", 66'(dm_write), 66'd0);
         next_cycle();
      end
      chk("t5_discarded", 66'(mem_word(200)), 66'h0);

      // Word load on a word store with identical address.
      dm_stall = 1'b1;
      store(32'd80, 32'hF0F0_F0F0, LS_WORD, st);
      mem_read        = 1'b1;
      mem_addr        = 32'd80;
      load_store_type = LS_WORD;
      load_unsigned   = 1'b0;
      @(negedge clk);
`ifdef STORE_FWD_EN
      chk("t6_fwd_data", 66'(mem_read_data), 66'hF0F0_F0F0);
      chk("t6_fwd_stall", 66'(stall), 66'd0);
      chk("t6_fwd_no_read", 66'(dm_read), 66'd0);
      next_cycle();
`else
      chk("t6_hit_stall", 66'(stall), 66'd1);
      chk("t6_hit_no_read", 66'(dm_read), 66'd0);
      next_cycle();
      dm_stall = 1'b0;
      @(negedge clk);
      chk("t6_drain_stall", 66'(stall), 66'd1);
      next_cycle();
      @(negedge clk);
      chk("t6_reissue_stall", 66'(stall), 66'd0);
      chk("t6_reissue_read", 66'(dm_read), 66'd1);
      chk("t6_reissue_data", 66'(mem_read_data), 66'hF0F0_F0F0);
      next_cycle();
`endif
      mem_read = 1'b0;
      dm_stall = 1'b0;
      wait_empty("t6_drained");
      chk("t6_mem", 66'(mem_word(80)), 66'hF0F0_F0F0);

      // Report
      chk("sb_all_drained", 66'(exp_q.size()), 66'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO between the EX/MEM pipeline register and data_memory_controller.
- Stores retire from the pipeline in one cycle and drain to data memory in the background.
- Loads bypass the queue unless they hit a buffered word; a hit stalls the load until that word has drained.
- Frees the pipeline from memory write latency and serialises all traffic onto the single data_memory_controller port.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width.
- DEPTH, 4, number of buffered stores; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_read  in  1  pipeline load request
- mem_write  in  1  pipeline store request
- mem_addr  in  ADDR_WIDTH  pipeline byte address
- mem_write_data  in  DATA_WIDTH  store data
- load_store_type  in  2  `LS_BYTE / `LS_HALF / `LS_WORD (controls.sv)
- load_unsigned  in  1  zero-extend load
- drain_req  in  1  fence; hold pipeline until buffer empty
- stall  out  1  freeze pipeline this cycle
- mem_read_data  out  DATA_WIDTH  load result to pipeline
- dm_addr, dm_write_data, dm_load_store_type, dm_load_unsigned  out  -  to data_memory_controller
- dm_read, dm_write  out  1  memory port strobes; never both high
- dm_read_data  in  DATA_WIDTH  from data_memory_controller
- dm_stall  in  1  controller busy; current dm op not taken

Behaviour:
- Reset (async, rst=1):
  - count=0, head/tail=0, all valid bits cleared.
  - stall=0, dm_read=0, dm_write=0, mem_read_data=0.
  - Pending stores are discarded. Reset mid-drain aborts with no further dm_write.
- Entry contents: {addr, data, load_store_type}; load_unsigned is not stored.
- Store enqueue (mem_write=1):
  - count<DEPTH: entry written at tail on the rising edge, stall=0. One-cycle pipeline latency.
  - count==DEPTH: stall=1, no enqueue. A simultaneous drain does not free the slot this cycle, so the store is accepted next cycle.
- Load (mem_read=1), word hit test = any valid entry with addr[ADDR_WIDTH-1:2]==mem_addr[ADDR_WIDTH-1:2]:
  - No hit: load owns the port this cycle. dm_read=1 and dm_addr/type/unsigned are driven combinationally from the pipeline; mem_read_data=dm_read_data, combinational. stall=dm_stall.
  - Hit: stall=1 and no dm_read. Drain continues; the load reissues once no entry matches.
- Drain:
  - When no load owns the port and count>0: dm_write=1 with the head entry; dm_load_unsigned=0.
  - Head pops on an edge with dm_stall=0.
  - Strict FIFO order; at most one drain per cycle.
- Simultaneous enqueue and drain: count unchanged; tail and head both advance. Pointers wrap modulo DEPTH.
- mem_read and mem_write both high is illegal; the store is taken and the read ignored.
- drain_req=1: stall=1 while count>0 or a dm_write is outstanding; stall=0 the cycle after count reaches 0.
- stall combines full, load hit, load dm_stall and drain_req. The pipeline holds its inputs stable while stall=1.

Optional Feature:
- Macro: STORE_FWD_EN.
- Defined: a load hit whose youngest matching entry is `LS_WORD with identical addr, and where the load is also `LS_WORD, returns that entry's data combinationally. stall=0 and no dm_read; the entry stays queued. All other hits stall as in base behaviour.
- Undefined: every hit stalls until drained; no forwarding logic is synthesised.

Test Plan:
- Reset, then 4 consecutive `LS_WORD stores (addr 0,4,8,12; data 1..4) with dm_stall=0 -> stall stays 0; memory sees dm_write in order 0,4,8,12; count returns to 0.
- Hold dm_stall=1 and issue 5 stores -> 5th cycle stall=1, count=4. Release dm_stall -> 5th store accepted the cycle after the first pop.
- Store `LS_BYTE 0xF0 to addr 22, then load `LS_BYTE signed from addr 20 with dm_stall=1 -> stall=1 until the entry drains. Then dm_read issues and mem_read_data=0xFFFFFFF0 for addr 22.
- Queue store to 80, then load from 150 -> load served same cycle with dm_read=1, stall=0; the store to 80 drains afterwards.
- Queue 3 stores, assert drain_req -> stall=1 for exactly the drain cycles, then 0. Assert rst mid-drain with 2 pending -> dm_write drops immediately; no further writes.
- STORE_FWD_EN: `LS_WORD store 0xF0F0F0F0 to 80 with dm_stall=1, then `LS_WORD load from 80 -> mem_read_data=0xF0F0F0F0, stall=0, dm_read=0. Without the macro the same load stalls until drained.
